// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions a raw, bouncing push-button pin for the single-bit button PIO.
// The pin is brought into the clk domain by a two-flop synchroniser and
// normalised to active-high. A new level is accepted only after it has been
// seen for DEBOUNCE_CYCLES consecutive samples. On acceptance the block drives
// a clean level plus a one-cycle press or release strobe.
//
// Optional feature (macro BUTTON_DEBOUNCE_LONGPRESS_EN):
//   When defined, a hold counter runs while the button is accepted as pressed.
//   long_press strobes once per press after LONG_CYCLES cycles of hold.
//   When undefined, long_press is tied low and no hold counter is built.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new level
//                    (legal range 2 .. 2**CNT_W-1)
//   CNT_W            debounce counter width
//   ACTIVE_LOW       1: the pin reads 0 when pressed; 0: the pin reads 1 when pressed
//   LONG_CYCLES      hold time for the long-press strobe (must be >= 2)
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset; every flop clears at once
//   btn_raw        asynchronous button pin
//   btn_level      debounced level, 1 = pressed (feeds PIO in_port)
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   long_press     one-cycle strobe on a long hold (0 unless the feature is built)
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    // Elaboration-time checks on the parameter ranges.
    if ((DEBOUNCE_CYCLES < 2) ||
        (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("button_debounce: LONG_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        REL   = 2'd0,  // stable released
        DEB_P = 2'd1,  // qualifying a press
        PRS   = 2'd2,  // stable pressed
        DEB_R = 2'd3   // qualifying a release
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // The synchroniser resets to the pin level of a released button, so
    // leaving reset never looks like an edge.
    localparam logic             PIN_IDLE = ACTIVE_LOW;

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    logic             s_d;          // synchronised sample, 1 = pressed
    logic             cnt_done_d;   // this sample completes qualification
    logic             press_acc_d;  // a press is accepted at this edge
    logic             rel_acc_d;    // a release is accepted at this edge

    assign s_d         = sync2_q ^ ACTIVE_LOW;
    assign cnt_done_d  = (cnt_q == CNT_LAST);
    assign press_acc_d = (state_q == DEB_P) && s_d && cnt_done_d;
    assign rel_acc_d   = (state_q == DEB_R) && !s_d && cnt_done_d;

    // Two-flop synchroniser on the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM with registered outputs. Any sample that disagrees with
    // the level being qualified drops straight back to the stable state, so
    // the counter is only ever a run length of identical samples. It is cleared
    // on every state change and never passes CNT_LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                REL: begin
                    if (s_d) begin
                        state_q <= DEB_P;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                DEB_P: begin
                    if (!s_d) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else if (cnt_done_d) begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                PRS: begin
                    if (!s_d) begin
                        state_q <= DEB_R;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                DEB_R: begin
                    if (s_d) begin
                        state_q   <= PRS;
                        cnt_q     <= '0;
                    end else if (cnt_done_d) begin
                        state_q   <= REL;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int unsigned     HOLD_W    = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // The hold counter keeps running through DEB_R. A rejected release glitch
    // therefore does not restart the long-press timing. It saturates at
    // HOLD_LAST, so the strobe fires only once per press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (press_acc_d || rel_acc_d) begin
                hold_q <= '0;
            end else if ((state_q == PRS) || (state_q == DEB_R)) begin
                if (hold_q != HOLD_LAST) begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HOLD_PRE) begin
                        long_q <= 1'b1;
                    end
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 and
// LONG_CYCLES=10. Inputs change 1 time unit after a rising edge, and outputs
// are sampled at that same point. A negedge monitor counts strobes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    localparam int LP = 1;
`else
    localparam int LP = 0;
`endif

    logic clk;
    logic reset_n;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    int long_cnt = 0;
    int overlap_cnt = 0;
    int p0, r0, l0;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .ACTIVE_LOW     (1'b1),
        .LONG_CYCLES    (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse)   press_cnt++;
        if (release_pulse) rel_cnt++;
        if (long_press)    long_cnt++;
        if (press_pulse && release_pulse) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        btn_raw = 1'b1;
        tick(3);
        chk("rst_level",   btn_level,     0);
        chk("rst_press",   press_pulse,   0);
        chk("rst_release", release_pulse, 0);
        chk("rst_long",    long_press,    0);

        // Idle after reset: released pin, nothing may happen.
        reset_n = 1'b1;
        tick(20);
        chk("idle_level",   btn_level, 0);
        chk("idle_presses", press_cnt, 0);
        chk("idle_rels",    rel_cnt,   0);

        // Clean press: level rises on the 6th edge after the pin change.
        btn_raw = 1'b0;
        tick(5);
        chk("press_early_level", btn_level,   0);
        chk("press_early_pulse", press_pulse, 0);
        tick(1);
        chk("press_level",       btn_level,   1);
        chk("press_pulse",       press_pulse, 1);
        tick(1);
        chk("press_pulse_1cyc",  press_pulse, 0);
        chk("press_level_hold",  btn_level,   1);
        chk("press_count",       press_cnt,   1);

        // Clean release.
        btn_raw = 1'b1;
        tick(5);
        chk("rel_early_level", btn_level,     1);
        tick(1);
        chk("rel_level",       btn_level,     0);
        chk("rel_pulse",       release_pulse, 1);
        tick(1);
        chk("rel_pulse_1cyc",  release_pulse, 0);

        // Bounce: 2-cycle toggles never qualify.
        p0 = press_cnt;
        r0 = rel_cnt;
        for (int i = 0; i < 15; i++) begin
            btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        btn_raw = 1'b1;
        tick(10);
        chk("bounce_level",   btn_level,      0);
        chk("bounce_presses", press_cnt - p0, 0);
        chk("bounce_rels",    rel_cnt - r0,   0);

        // Press, then release with a 3-cycle pressed glitch 2 cycles in.
        btn_raw = 1'b0;
        tick(7);
        chk("glitch_pre_level", btn_level, 1);
        r0 = rel_cnt;
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(3);
        btn_raw = 1'b1;
        tick(5);
        chk("glitch_level_held", btn_level,     1);
        tick(1);
        chk("glitch_rel_level",  btn_level,     0);
        chk("glitch_rel_pulse",  release_pulse, 1);
        tick(1);
        chk("glitch_rel_1cyc",   release_pulse, 0);
        chk("glitch_rel_count",  rel_cnt - r0,  1);

        // Reset while qualifying a press (counter at 2).
        btn_raw = 1'b0;
        tick(4);
        chk("midp_level_before", btn_level, 0);
        reset_n = 1'b0;
        #1;
        chk("midp_rst_level", btn_level,   0);
        chk("midp_rst_press", press_pulse, 0);
        tick(2);
        reset_n = 1'b1;
        p0 = press_cnt;
        tick(5);
        chk("requal_early_level", btn_level,   0);
        tick(1);
        chk("requal_level",       btn_level,   1);
        chk("requal_pulse",       press_pulse, 1);
        tick(1);
        chk("requal_count",       press_cnt - p0, 1);

        // Long hold: strobe 9 cycles after the level rose, once only.
        l0 = long_cnt;
        tick(7);
        chk("long_early", long_press, 0);
        tick(1);
        chk("long_pulse", long_press, LP);
        tick(1);
        chk("long_1cyc",  long_press, 0);
        tick(10);
        chk("long_count", long_cnt - l0, LP);
        chk("long_level", btn_level, 1);

        // Reset asserted mid-cycle from the pressed state clears the level at once.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_level", btn_level, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        chk("press_release_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
